// File: rtl/barrett_pkg.sv
// Shared constants and sideband type for the Barrett reduction pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package barrett_pkg;

    // Number of register stages between input acceptance and result.
    localparam int LATENCY   = 5;

    // Default modulus width in bits.
    localparam int K_DEF     = 32;

    // Widest tag the sideband chain can carry; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 16;

    // Per-stage control sideband that travels alongside the datapath.
    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [TAG_W_MAX-1:0] tag;
    } stage_sb_t;

endpackage : barrett_pkg

// File: rtl/barrett_pipe_ctrl.sv
// Valid/err/tag shift chain for the Barrett pipeline; generates the global enable.
// Latency: LATENCY cycles from acceptance to valid_o, all stages move together.
// Backpressure: global stall, en = !valid_o || ready_i; bubbles are kept, not collapsed.
module barrett_pipe_ctrl
    import barrett_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             err_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             ready_i,
    output logic             en_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             pre_valid_o,
    output logic             pre_err_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [TAG_W-1:0] tag_o
);

    stage_sb_t sb_q [LATENCY];
    stage_sb_t sb_in;
    logic      en;
    logic      unused_tag_hi;

    // Pack the incoming transaction's control fields into the sideband format.
    always_comb begin
        sb_in                  = '0;
        sb_in.valid            = valid_i;
        sb_in.err              = err_i;
        sb_in.tag[TAG_W-1:0]   = tag_i;
    end

    // The pipe may move whenever the output slot is empty or being drained.
    assign en      = !sb_q[LATENCY-1].valid || ready_i;
    assign en_o    = en;
    assign ready_o = en;

    // Shift chain: every stage advances on en; reset drops all in-flight work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                sb_q[i] <= '0;
            end
        end else if (en) begin
            sb_q[0] <= sb_in;
            for (int i = 1; i < LATENCY; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    // Busy whenever any stage holds a live transaction.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_o = busy_o | sb_q[i].valid;
        end
    end

    // The stage feeding the output register decides whether the result is forced to zero.
    assign pre_valid_o = sb_q[LATENCY-2].valid;
    assign pre_err_o   = sb_q[LATENCY-2].err;

    assign valid_o = sb_q[LATENCY-1].valid;
    assign err_o   = sb_q[LATENCY-1].err;
    assign tag_o   = sb_q[LATENCY-1].tag[TAG_W-1:0];

    // Upper tag bits are always zero when TAG_W < TAG_W_MAX.
    assign unused_tag_hi = ^sb_q[LATENCY-1].tag;

endmodule : barrett_pipe_ctrl

// File: rtl/barrett_reduce_pipe.sv
// Fully pipelined Barrett reducer: result = x mod m, per-transaction m, mu and tag.
// Latency: 5 register stages, one result per cycle when ready_i stays high.
// Backpressure: global stall; all stages freeze and ready_o drops while valid_o && !ready_i.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2*K-1:0]   x_i,
    input  logic [K-1:0]     m_i,
    input  logic [K+1:0]     mu_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [K-1:0]     result_o,
    output logic             err_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int PW  = 3*K + 2;   // x * mu product width
    localparam int QW  = K + 2;     // quotient estimate width
    localparam int RW  = K + 1;     // residue window; r0 < 2m fits here
    localparam int QMW = 2*K + 2;   // full q * m width

    logic en;
    logic err_in;
    logic pre_valid;
    logic pre_err;

    // Unnormalised modulus is flagged at acceptance and rides with the transaction.
    assign err_in = ~m_i[K-1];

    barrett_pipe_ctrl #(
        .TAG_W (TAG_W)
    ) u_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .err_i       (err_in),
        .tag_i       (tag_i),
        .ready_i     (ready_i),
        .en_o        (en),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .pre_valid_o (pre_valid),
        .pre_err_o   (pre_err),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .tag_o       (tag_o)
    );

    // ---------------- S1: p = x * mu ----------------
    logic [PW-1:0] p_full;
    logic [PW-1:0] s1_p;
    logic [RW-1:0] s1_x;
    logic [K-1:0]  s1_m;

    assign p_full = {{(K+2){1'b0}}, x_i} * {{(2*K){1'b0}}, mu_i};

    // Capture the product; only the low RW bits of x are needed downstream.
    always_ff @(posedge clk_i) begin
        if (en) begin
            s1_p <= p_full;
            s1_x <= x_i[RW-1:0];
            s1_m <= m_i;
        end
    end

    // ---------------- S2: q = p >> 2K ----------------
    logic [QW-1:0] s2_q;
    logic [RW-1:0] s2_x;
    logic [K-1:0]  s2_m;

    // Quotient estimate is the top K+2 bits of the product.
    always_ff @(posedge clk_i) begin
        if (en) begin
            s2_q <= s1_p[PW-1:2*K];
            s2_x <= s1_x;
            s2_m <= s1_m;
        end
    end

    // ---------------- S3: qm = q * m (low K+1 bits) ----------------
    logic [QMW-1:0] qm_full;
    logic [RW-1:0]  s3_qm;
    logic [RW-1:0]  s3_x;
    logic [K-1:0]   s3_m;

    assign qm_full = {{K{1'b0}}, s2_q} * {{(K+2){1'b0}}, s2_m};

    // Only the residue window matters since x - qm < 2m < 2^(K+1).
    always_ff @(posedge clk_i) begin
        if (en) begin
            s3_qm <= qm_full[RW-1:0];
            s3_x  <= s2_x;
            s3_m  <= s2_m;
        end
    end

    // ---------------- S4: r0 = (x - qm) mod 2^(K+1) ----------------
    logic [RW-1:0] s4_r0;
    logic [K-1:0]  s4_m;

    // Modular subtraction; wraparound in the high bits is intentional.
    always_ff @(posedge clk_i) begin
        if (en) begin
            s4_r0 <= s3_x - s3_qm;
            s4_m  <= s3_m;
        end
    end

    // ---------------- S5: single conditional correction ----------------
    logic [RW-1:0] s5_diff;
    logic          s5_ge;
    logic [RW-1:0] s5_res;

    always_comb begin
        s5_diff = s4_r0 - {1'b0, s4_m};
        s5_ge   = (s4_r0 >= {1'b0, s4_m});
        s5_res  = s5_ge ? s5_diff : s4_r0;
    end

    // Output register: zero for bubbles and for unnormalised-modulus transactions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= '0;
        end else if (en) begin
            if (pre_valid && !pre_err) begin
                result_o <= s5_res[K-1:0];
            end else begin
                result_o <= '0;
            end
        end
    end

    // Discarded product bits: low half of x*mu, high half of q*m, and the
    // top residue bit which is always zero after correction.
    logic unused_bits;
    assign unused_bits = ^{s1_p[2*K-1:0], qm_full[QMW-1:RW], s5_res[K]};

endmodule : barrett_reduce_pipe

// File: tb/tb_barrett_reduce_pipe.sv
module tb_barrett_reduce_pipe;

    localparam int K     = 8;
    localparam int TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [2*K-1:0]   x_i;
    logic [K-1:0]     m_i;
    logic [K+1:0]     mu_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [K-1:0]     result_o;
    logic             err_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    // stimulus / expectation tables for streamed tests
    int vx  [16];
    int vm  [16];
    int vmu [16];
    int vt  [16];
    int er  [16];
    int ee  [16];

    barrett_reduce_pipe #(.K(K), .TAG_W(TAG_W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .x_i      (x_i),
        .m_i      (m_i),
        .mu_i     (mu_i),
        .tag_i    (tag_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .err_o    (err_o),
        .tag_o    (tag_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Single transaction into an empty pipe; checks 5-cycle latency and outputs.
    task automatic run_one(input int x, input int m, input int mu, input int tg,
                           input int exp_r, input int exp_e, input string name);
        int lat;
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        x_i     = x[2*K-1:0];
        m_i     = m[K-1:0];
        mu_i    = mu[K+1:0];
        tag_i   = tg[TAG_W-1:0];
        lat     = 0;
        while (lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
            if (lat == 1) valid_i = 1'b0;
            if (valid_o) break;
        end
        chk({name, "_latency"}, lat, 5);
        chk({name, "_result"}, {24'd0, result_o}, exp_r);
        chk({name, "_err"}, {31'd0, err_o}, exp_e);
        chk({name, "_tag"}, {28'd0, tag_o}, tg);
    endtask

    // Push n table entries back to back, honouring ready_o.
    task automatic drive_stream(input int n);
        bit acc;
        int w;
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b1;
            x_i     = vx[i][2*K-1:0];
            m_i     = vm[i][K-1:0];
            mu_i    = vmu[i][K+1:0];
            tag_i   = vt[i][TAG_W-1:0];
            acc     = 1'b0;
            w       = 0;
            while (!acc && w < 100) begin
                @(negedge clk_i); #2;
                acc = ready_o;
                @(posedge clk_i); #1;
                w++;
            end
            chk("drive_accept", {31'd0, acc}, 1);
        end
        valid_i = 1'b0;
    endtask

    // Collect n results in order; optionally stall 3 cycles at the 4th output.
    task automatic monitor(input int n, input bit do_stall, input string name);
        int got;
        int cyc;
        int extra;
        bit stalled;
        logic [K-1:0]     hr;
        logic [TAG_W-1:0] ht;
        got     = 0;
        cyc     = 0;
        extra   = 0;
        stalled = 1'b0;
        while (got < n && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            if (valid_o) begin
                if (do_stall && !stalled && got == 3) begin
                    stalled = 1'b1;
                    ready_i = 1'b0;
                    hr      = result_o;
                    ht      = tag_o;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk_i);
                        cyc++;
                        chk({name, "_stall_valid"}, {31'd0, valid_o}, 1);
                        chk({name, "_stall_result"}, {24'd0, result_o}, {24'd0, hr});
                        chk({name, "_stall_tag"}, {28'd0, tag_o}, {28'd0, ht});
                        chk({name, "_stall_ready_o"}, {31'd0, ready_o}, 0);
                    end
                    ready_i = 1'b1;
                end
                chk({name, "_result"}, {24'd0, result_o}, er[got]);
                chk({name, "_err"}, {31'd0, err_o}, ee[got]);
                chk({name, "_tag"}, {28'd0, tag_o}, vt[got]);
                got++;
            end
        end
        chk({name, "_count"}, got, n);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk_i);
            if (valid_o) extra++;
        end
        chk({name, "_no_dup"}, extra, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        x_i     = '0;
        m_i     = '0;
        mu_i    = '0;
        tag_i   = '0;

        // reset state
        #3;
        chk("rst_valid_o", {31'd0, valid_o}, 0);
        chk("rst_ready_o", {31'd0, ready_o}, 1);
        chk("rst_busy_o", {31'd0, busy_o}, 0);
        chk("rst_result_o", {24'd0, result_o}, 0);
        chk("rst_err_o", {31'd0, err_o}, 0);
        chk("rst_tag_o", {28'd0, tag_o}, 0);

        @(posedge clk_i); #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;

        // directed single transactions
        run_one(65000, 251, 261, 3, 242, 0, "no_corr");
        run_one(65535, 251, 261, 1, 24, 0, "one_corr");
        run_one(65535, 128, 512, 2, 127, 0, "m_min");
        run_one(0, 255, 257, 4, 0, 0, "x_zero");

        // unnormalised modulus followed immediately by a good transaction
        vx[0] = 1234;  vm[0] = 1;   vmu[0] = 0;   vt[0] = 9; er[0] = 0;   ee[0] = 1;
        vx[1] = 65000; vm[1] = 251; vmu[1] = 261; vt[1] = 5; er[1] = 242; ee[1] = 0;
        @(posedge clk_i); #1;
        fork
            drive_stream(2);
            monitor(2, 1'b0, "unnorm");
        join

        // 10 random normalised ops back to back with a 3-cycle stall mid-stream
        for (int i = 0; i < 10; i++) begin
            vm[i]  = 128 + $urandom_range(127, 0);
            vx[i]  = $urandom_range(65535, 0);
            vmu[i] = 65536 / vm[i];
            vt[i]  = i;
            er[i]  = vx[i] % vm[i];
            ee[i]  = 0;
        end
        @(posedge clk_i); #1;
        fork
            drive_stream(10);
            monitor(10, 1'b1, "stream");
        join

        // reset with four transactions in flight and the oldest waiting at the output
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            x_i     = 16'(1000 + i);
            m_i     = 8'd200;
            mu_i    = 10'd327;
            tag_i   = 4'(i);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pre_rst_valid_o", {31'd0, valid_o}, 1);
        chk("pre_rst_busy_o", {31'd0, busy_o}, 1);
        chk("pre_rst_ready_o", {31'd0, ready_o}, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid_o", {31'd0, valid_o}, 0);
        chk("mid_rst_busy_o", {31'd0, busy_o}, 0);
        chk("mid_rst_ready_o", {31'd0, ready_o}, 1);
        chk("mid_rst_result_o", {24'd0, result_o}, 0);
        chk("mid_rst_tag_o", {28'd0, tag_o}, 0);
        @(posedge clk_i); #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        run_one(300, 200, 327, 6, 100, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_barrett_reduce_pipe
